// File: rtl/sha2_core_mr_if.sv
// rtl/sha2_core_mr_if.sv - block/digest handshake bundle for the SHA-2 multi-round core
// Signals:
//   in_valid/in_ready   block handshake (block_in, mode, chain qualified by in_valid)
//   block_in            512-bit message block, word 0 in [511:480]
//   mode                0 = SHA-256, 1 = SHA-224 (used only when chain = 0)
//   chain               1 = continue from the core's running hash
//   abort               cancel the block currently being compressed
//   out_valid/out_ready digest handshake
//   hash_out            {H0..H7}; low word zero in SHA-224 mode
//   busy                core is not idle
// Modports: master drives blocks and consumes digests, slave is the core.
interface sha2_core_mr_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_in;
  logic         mode;
  logic         chain;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] hash_out;
  logic         busy;

  modport master (
    output in_valid, block_in, mode, chain, abort, out_ready,
    input  in_ready, out_valid, hash_out, busy
  );

  modport slave (
    input  in_valid, block_in, mode, chain, abort, out_ready,
    output in_ready, out_valid, hash_out, busy
  );
endinterface

// File: rtl/sha2_core_mr.sv
// rtl/sha2_core_mr.sv - multi-round SHA-224/SHA-256 compression core with internal hash chaining
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sha2_core_mr_if.slave: block input handshake, digest output handshake, busy
// One 512-bit block per transaction, ROUNDS_PER_CYCLE rounds per clock, message schedule
// expanded in a 16-word sliding window. The running hash stays inside the core so chained
// blocks need no external feedback.
module sha2_core_mr #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int DEBUG            = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  sha2_core_mr_if.slave bus
);
  localparam int R = ROUNDS_PER_CYCLE;

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_COMP, S_FIN, S_OUT} state_t;

  generate
    if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
      $error("sha2_core_mr: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
    if (DEBUG != 0 && DEBUG != 1) begin : g_bad_debug
      $error("sha2_core_mr: DEBUG must be 0 or 1");
    end
  endgenerate

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t ror(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t       state_q, state_d;
  word_t        h_q  [8];
  word_t        h_d  [8];
  word_t        wv_q [8];
  word_t        wv_d [8];
  word_t        w_q  [16];
  word_t        w_d  [16];
  logic [6:0]   t_q, t_d;
  logic         mode_q, mode_d;
  logic [255:0] hash_q, hash_d;
  logic         ov_q, ov_d;

  // ext[0..15] is the window (W[t..t+15]); ext[16..15+R] are the words this
  // edge appends, so round j of this edge always consumes ext[j] = W[t+j].
  word_t ext [16+R];
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
  end

  // R rounds chained combinationally; rs[j] holds a..h entering round t+j.
  word_t rs [R+1][8];
  word_t t1, t2;
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 8; i++) rs[0][i] = wv_q[i];
    for (int j = 0; j < R; j++) begin
      t1 = rs[j][7] + bsig1(rs[j][4]) + ((rs[j][4] & rs[j][5]) ^ (~rs[j][4] & rs[j][6]))
         + K[t_q[5:0] + 6'(j)] + ext[j];
      t2 = bsig0(rs[j][0])
         + ((rs[j][0] & rs[j][1]) ^ (rs[j][0] & rs[j][2]) ^ (rs[j][1] & rs[j][2]));
      rs[j+1][0] = t1 + t2;
      rs[j+1][1] = rs[j][0];
      rs[j+1][2] = rs[j][1];
      rs[j+1][3] = rs[j][2];
      rs[j+1][4] = rs[j][3] + t1;
      rs[j+1][5] = rs[j][4];
      rs[j+1][6] = rs[j][5];
      rs[j+1][7] = rs[j][6];
    end
  end

  // h_q only changes on a chain=0 accept or a completed FIN, so an abort
  // leaves it at its accept-edge value without any separate snapshot.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    wv_d    = wv_q;
    w_d     = w_q;
    t_d     = t_q;
    mode_d  = mode_q;
    hash_d  = hash_q;
    ov_d    = ov_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          for (int i = 0; i < 16; i++) w_d[i] = bus.block_in[511 - 32*i -: 32];
          if (!bus.chain) begin
            mode_d = bus.mode;
            for (int i = 0; i < 8; i++) h_d[i] = bus.mode ? IV224[i] : IV256[i];
          end
          for (int i = 0; i < 8; i++) wv_d[i] = h_d[i];
          t_d     = '0;
          state_d = S_COMP;
        end
      end
      S_COMP: begin
        if (bus.abort) begin
          t_d     = '0;
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < 8; i++)  wv_d[i] = rs[R][i];
          for (int i = 0; i < 16; i++) w_d[i]  = ext[i+R];
          t_d = t_q + 7'(R);
          if (t_q + 7'(R) == 7'd64) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (bus.abort) begin
          t_d     = '0;
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
          hash_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], h_d[7]};
          if (mode_q) hash_d[31:0] = '0;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= IV256[i];
        wv_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      t_q    <= '0;
      mode_q <= 1'b0;
      hash_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      wv_q    <= wv_d;
      w_q     <= w_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      hash_q  <= hash_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = ov_q;
  assign bus.hash_out  = hash_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sha2_core_mr.sv
// tb/tb_sha2_core_mr.sv - scoreboard bench for sha2_core_mr at 1, 2 and 4 rounds per cycle
module tb_sha2_core_mr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sha2_core_mr_if if1 ();
  sha2_core_mr_if if2 ();
  sha2_core_mr_if if4 ();

  int           sel = 1;
  logic         in_valid_s = 1'b0;
  logic         mode_s = 1'b0;
  logic         chain_s = 1'b0;
  logic         abort_s = 1'b0;
  logic         out_ready_s = 1'b0;
  logic [511:0] block_s = '0;

  assign if1.in_valid  = in_valid_s & (sel == 1);
  assign if1.block_in  = block_s;
  assign if1.mode      = mode_s;
  assign if1.chain     = chain_s;
  assign if1.abort     = abort_s & (sel == 1);
  assign if1.out_ready = out_ready_s & (sel == 1);
  assign if2.in_valid  = in_valid_s & (sel == 2);
  assign if2.block_in  = block_s;
  assign if2.mode      = mode_s;
  assign if2.chain     = chain_s;
  assign if2.abort     = abort_s & (sel == 2);
  assign if2.out_ready = out_ready_s & (sel == 2);
  assign if4.in_valid  = in_valid_s & (sel == 4);
  assign if4.block_in  = block_s;
  assign if4.mode      = mode_s;
  assign if4.chain     = chain_s;
  assign if4.abort     = abort_s & (sel == 4);
  assign if4.out_ready = out_ready_s & (sel == 4);

  wire         ov   = (sel == 1) ? if1.out_valid : (sel == 2) ? if2.out_valid : if4.out_valid;
  wire         ir   = (sel == 1) ? if1.in_ready  : (sel == 2) ? if2.in_ready  : if4.in_ready;
  wire         busy = (sel == 1) ? if1.busy      : (sel == 2) ? if2.busy      : if4.busy;
  wire [255:0] hout = (sel == 1) ? if1.hash_out  : (sel == 2) ? if2.hash_out  : if4.hash_out;

  sha2_core_mr #(.ROUNDS_PER_CYCLE(1), .DEBUG(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sha2_core_mr #(.ROUNDS_PER_CYCLE(2), .DEBUG(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  sha2_core_mr #(.ROUNDS_PER_CYCLE(4), .DEBUG(0)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 32'h00000000, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  typedef struct {
    string        tag;
    logic [255:0] digest;
    bit           care;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [511:0] blk, input logic md, input logic ch,
                      input logic [255:0] dg, input bit care, input int lat, input bit push);
    int   n;
    exp_t e;
    n = 0;
    block_s    = blk;
    mode_s     = md;
    chain_s    = ch;
    in_valid_s = 1'b1;
    while (!ir && n < 400) begin
      step();
      n++;
    end
    if (!ir) begin
      check({tag, "_accept_timeout"}, 256'd0, 256'd1);
      in_valid_s = 1'b0;
      return;
    end
    step();
    in_valid_s = 1'b0;
    acc_cyc    = cyc;
    check({tag, "_busy_after_accept"}, {255'd0, busy}, 256'd1);
    if (push) begin
      e.tag    = tag;
      e.digest = dg;
      e.care   = care;
      e.lat    = lat;
      sb.push_back(e);
    end
  endtask

  task automatic recv(input int stall, input bit poke);
    exp_t e;
    int   n;
    n = 0;
    out_ready_s = 1'b0;
    while (!ov && n < 400) begin
      step();
      n++;
    end
    if (!ov) begin
      check("out_valid_timeout", 256'd0, 256'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 256'd0, 256'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_latency"}, 256'(cyc - acc_cyc), 256'(e.lat));
    if (e.care) check({e.tag, "_digest"}, hout, e.digest);
    if (poke) begin
      block_s    = BLK_ABC;
      chain_s    = 1'b0;
      in_valid_s = 1'b1;
    end
    for (int k = 0; k < stall; k++) begin
      step();
      check({e.tag, "_stall_out_valid"}, {255'd0, ov}, 256'd1);
      check({e.tag, "_stall_in_ready"}, {255'd0, ir}, 256'd0);
      if (e.care) check({e.tag, "_stall_digest"}, hout, e.digest);
    end
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    step();
    out_ready_s = 1'b0;
    check({e.tag, "_out_valid_drop"}, {255'd0, ov}, 256'd0);
    check({e.tag, "_in_ready_back"}, {255'd0, ir}, 256'd1);
    check({e.tag, "_idle_busy"}, {255'd0, busy}, 256'd0);
  endtask

  initial begin
    int rsel [3];
    rsel = '{1, 2, 4};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = rsel[i];
      #1;
      check("reset_in_ready", {255'd0, ir}, 256'd1);
      check("reset_out_valid", {255'd0, ov}, 256'd0);
      check("reset_busy", {255'd0, busy}, 256'd0);
      check("reset_hash_out", hout, 256'd0);
    end
    rst_n = 1'b1;
    step();

    sel = 1;
    send("r1_abc256", BLK_ABC, 1'b0, 1'b0, D_ABC256, 1'b1, 65, 1'b1);
    recv(0, 1'b0);

    sel = 4;
    send("r4_abc224", BLK_ABC, 1'b1, 1'b0, D_ABC224, 1'b1, 17, 1'b1);
    recv(0, 1'b0);

    sel = 2;
    send("r2_two_blk1", BLK_TWO1, 1'b0, 1'b0, 256'd0, 1'b0, 33, 1'b1);
    recv(0, 1'b0);
    send("r2_two_blk2", BLK_TWO2, 1'b1, 1'b1, D_TWO, 1'b1, 33, 1'b1);
    recv(0, 1'b0);

    sel = 1;
    send("r1_empty_stall", BLK_EMPTY, 1'b0, 1'b0, D_EMPTY, 1'b1, 65, 1'b1);
    recv(10, 1'b1);

    sel = 2;
    send("r2_abort_blk1", BLK_TWO1, 1'b0, 1'b0, 256'd0, 1'b0, 33, 1'b1);
    recv(0, 1'b0);
    send("r2_abort_blk2", BLK_TWO2, 1'b0, 1'b1, 256'd0, 1'b0, 0, 1'b0);
    repeat (15) step();
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    check("abort_out_valid", {255'd0, ov}, 256'd0);
    check("abort_in_ready", {255'd0, ir}, 256'd1);
    check("abort_busy", {255'd0, busy}, 256'd0);
    send("r2_resend_blk2", BLK_TWO2, 1'b0, 1'b1, D_TWO, 1'b1, 33, 1'b1);
    recv(0, 1'b0);

    sel = 1;
    send("r1_reset_mid", BLK_ABC, 1'b0, 1'b0, 256'd0, 1'b0, 0, 1'b0);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {255'd0, ov}, 256'd0);
    check("midreset_in_ready", {255'd0, ir}, 256'd1);
    check("midreset_busy", {255'd0, busy}, 256'd0);
    step();
    rst_n = 1'b1;
    step();
    send("r1_chain_after_reset", BLK_ABC, 1'b1, 1'b1, D_ABC256, 1'b1, 65, 1'b1);
    recv(0, 1'b0);

    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
